// File: rtl/lcd_bus_pkg.sv
// Shared 8080-bus definitions for the LCD reader and command writer: FSM states,
// default phase timing at 50 MHz, and ILI9325 identification constants.
package lcd_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_IDX_SETUP   = 3'd1,
    ST_IDX_WR_LOW  = 3'd2,
    ST_IDX_WR_HIGH = 3'd3,
    ST_TURN        = 3'd4,
    ST_RD_LOW      = 3'd5,
    ST_RD_HIGH     = 3'd6,
    ST_DONE        = 3'd7
  } rd_state_e;

  localparam int DEF_WR_LOW_CYC  = 3;
  localparam int DEF_WR_HIGH_CYC = 3;
  localparam int DEF_TURN_CYC    = 2;
  localparam int DEF_RD_LOW_CYC  = 12;
  localparam int DEF_RD_HIGH_CYC = 12;
  localparam int DEF_CNT_W       = 8;

  localparam logic [15:0] REG_DEVICE_CODE = 16'h0000;
  localparam logic [15:0] DEVICE_ID       = 16'h9325;

  // The index phases are the only ones in which we own the data bus.
  function automatic logic is_idx_state(input rd_state_e s);
    return (s == ST_IDX_SETUP) || (s == ST_IDX_WR_LOW) || (s == ST_IDX_WR_HIGH);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that times one bus phase; zero flags the last cycle of the phase.
// Load takes priority over counting; the counter parks at zero and never wraps.
module lcd_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_reg_reader.sv
// Reads one ILI9325 register: index write (RS=0, WR strobe) then data read (RS=1, RD strobe).
// done_o lands 1+WR_LOW+WR_HIGH+TURN+RD_LOW+RD_HIGH edges after accept; start_i is dropped while busy.
module lcd_reg_reader
  import lcd_bus_pkg::*;
#(
  parameter int WR_LOW_CYC  = DEF_WR_LOW_CYC,
  parameter int WR_HIGH_CYC = DEF_WR_HIGH_CYC,
  parameter int TURN_CYC    = DEF_TURN_CYC,
  parameter int RD_LOW_CYC  = DEF_RD_LOW_CYC,
  parameter int RD_HIGH_CYC = DEF_RD_HIGH_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_ready_i,
  input  logic        start_i,
  input  logic [15:0] reg_addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        abort_o,
  output logic [15:0] rd_data_o,
  output logic        lcd_cs_n_o,
  output logic        lcd_rs_o,
  output logic        lcd_wr_n_o,
  output logic        lcd_rd_n_o,
  output logic [15:0] lcd_data_o,
  output logic        lcd_data_oe_o,
  input  logic [15:0] lcd_data_i
);

  localparam logic [CNT_W-1:0] WR_LOW_LD  = CNT_W'(WR_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] WR_HIGH_LD = CNT_W'(WR_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD    = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LOW_LD  = CNT_W'(RD_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] RD_HIGH_LD = CNT_W'(RD_HIGH_CYC - 1);

  rd_state_e        state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic             tmr_load, tmr_zero, abort_d, capture;
  logic [CNT_W-1:0] tmr_val;

  lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    abort_d  = 1'b0;
    capture  = 1'b0;
    // Losing ready abandons the transfer, except in DONE where the data is already captured.
    if (state_q != ST_IDLE && state_q != ST_DONE && !lcd_ready_i) begin
      state_d = ST_IDLE;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && lcd_ready_i) begin
            state_d = ST_IDX_SETUP;
            addr_d  = reg_addr_i;
          end
        end
        ST_IDX_SETUP: begin
          state_d  = ST_IDX_WR_LOW;
          tmr_load = 1'b1;
          tmr_val  = WR_LOW_LD;
        end
        ST_IDX_WR_LOW: begin
          if (tmr_zero) begin
            state_d  = ST_IDX_WR_HIGH;
            tmr_load = 1'b1;
            tmr_val  = WR_HIGH_LD;
          end
        end
        ST_IDX_WR_HIGH: begin
          if (tmr_zero) begin
            state_d  = ST_TURN;
            tmr_load = 1'b1;
            tmr_val  = TURN_LD;
          end
        end
        ST_TURN: begin
          if (tmr_zero) begin
            state_d  = ST_RD_LOW;
            tmr_load = 1'b1;
            tmr_val  = RD_LOW_LD;
          end
        end
        ST_RD_LOW: begin
          if (tmr_zero) begin
            state_d  = ST_RD_HIGH;
            tmr_load = 1'b1;
            tmr_val  = RD_HIGH_LD;
            capture  = 1'b1;
          end
        end
        ST_RD_HIGH: begin
          if (tmr_zero) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so pins change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_cs_n_o    <= 1'b1;
      lcd_rs_o      <= 1'b1;
      lcd_wr_n_o    <= 1'b1;
      lcd_rd_n_o    <= 1'b1;
      lcd_data_oe_o <= 1'b0;
      lcd_data_o    <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      abort_o       <= 1'b0;
      rd_data_o     <= '0;
    end else begin
      lcd_cs_n_o    <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      lcd_rs_o      <= !is_idx_state(state_d);
      lcd_wr_n_o    <= (state_d != ST_IDX_WR_LOW);
      lcd_rd_n_o    <= (state_d != ST_RD_LOW);
      lcd_data_oe_o <= is_idx_state(state_d);
      lcd_data_o    <= is_idx_state(state_d) ? addr_d : 16'h0000;
      busy_o        <= (state_d != ST_IDLE);
      done_o        <= (state_d == ST_DONE);
      abort_o       <= abort_d;
      if (capture) begin
        rd_data_o <= lcd_data_i;
      end
    end
  end

endmodule

// File: tb/tb_lcd_reg_reader.sv
// Directed bench for lcd_reg_reader with an ILI9325 register model on the bus,
// a read-data scoreboard and a strobe/ownership protocol monitor.
module tb_lcd_reg_reader;
  import lcd_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lcd_ready_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] reg_addr_i = 16'h0000;
  logic        busy_o, done_o, abort_o;
  logic [15:0] rd_data_o;
  logic        lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_rd_n_o, lcd_data_oe_o;
  logic [15:0] lcd_data_o, lcd_data_i;
  logic [15:0] model_idx = 16'hFFFF;
  logic [15:0] last_idx = 16'hFFFF;

  int tests = 0, fails = 0;
  int cs_low = 0, wr_low = 0, busy_cnt = 0, done_cnt = 0, abort_cnt = 0;
  int prot_err = 0, sb_underflow = 0;
  logic prev_done = 1'b0, prev_abort = 1'b0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  lcd_reg_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lcd_ready_i   (lcd_ready_i),
    .start_i       (start_i),
    .reg_addr_i    (reg_addr_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .abort_o       (abort_o),
    .rd_data_o     (rd_data_o),
    .lcd_cs_n_o    (lcd_cs_n_o),
    .lcd_rs_o      (lcd_rs_o),
    .lcd_wr_n_o    (lcd_wr_n_o),
    .lcd_rd_n_o    (lcd_rd_n_o),
    .lcd_data_o    (lcd_data_o),
    .lcd_data_oe_o (lcd_data_oe_o),
    .lcd_data_i    (lcd_data_i)
  );

  function automatic logic [15:0] reg_model(input logic [15:0] idx);
    case (idx)
      REG_DEVICE_CODE: return DEVICE_ID;
      16'h00A5:        return 16'h1234;
      16'h0001:        return 16'h00BE;
      default:         return 16'hFFFF;
    endcase
  endfunction

  // Panel model: latches the index on the WR rising edge and drives its register while RD is low.
  always @(posedge lcd_wr_n_o) if (!lcd_rs_o && lcd_data_oe_o) model_idx = lcd_data_o;
  assign lcd_data_i = !lcd_rd_n_o ? reg_model(model_idx) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!lcd_cs_n_o) cs_low++;
    if (busy_o) busy_cnt++;
    if (!lcd_wr_n_o) begin
      wr_low++;
      last_idx = lcd_data_o;
      if (!lcd_data_oe_o || lcd_rs_o || lcd_cs_n_o) prot_err++;
    end
    if (!lcd_wr_n_o && !lcd_rd_n_o) prot_err++;
    if (lcd_data_oe_o && !lcd_rd_n_o) prot_err++;
    if (!lcd_rd_n_o && (!lcd_rs_o || lcd_cs_n_o)) prot_err++;
    if ((done_o && prev_done) || (abort_o && prev_abort) || (done_o && abort_o)) prot_err++;
    if (abort_o) abort_cnt++;
    if (done_o) begin
      done_cnt++;
      if (sb_q.size() == 0) sb_underflow++;
      else check("sb_rd_data", rd_data_o, sb_q.pop_front());
    end
    prev_done  = done_o;
    prev_abort = abort_o;
  end

  // One read: start for a single edge, optional start-while-busy and ready-drop injections.
  task automatic run_txn(input logic [15:0] addr, input int busy_at, input int drop_at,
                         output int lat, output int ab);
    if (drop_at == 0) sb_q.push_back(reg_model(addr));
    reg_addr_i = addr;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = -1;
    ab = -1;
    for (int i = 1; i <= 60; i++) begin
      start_i = (i == busy_at);
      if (i == busy_at) reg_addr_i = 16'h0001;
      if (i == drop_at) lcd_ready_i = 1'b0;
      @(posedge clk); #1;
      if (done_o && lat < 0) lat = i;
      if (abort_o && ab < 0) ab = i;
      if (!busy_o) break;
    end
    start_i = 1'b0;
  endtask

  initial begin
    int lat, ab, d1, d2, idle_gap, base_done, base_abort;

    repeat (3) @(posedge clk); #1;
    check("rst_bus", {lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_rd_n_o, lcd_data_oe_o}, 5'b11110);
    check("rst_data_o", lcd_data_o, 0);
    check("rst_status", {busy_o, done_o, abort_o}, 0);
    check("rst_rd_data", rd_data_o, 0);
    rst_n = 1'b1;
    lcd_ready_i = 1'b1;
    @(posedge clk); #1;

    // Basic device-code read
    cs_low = 0;
    wr_low = 0;
    last_idx = 16'hFFFF;
    sb_q.push_back(reg_model(REG_DEVICE_CODE));
    reg_addr_i = REG_DEVICE_CODE;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("setup_bus", {busy_o, lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_data_oe_o}, 5'b10011);
    lat = -1;
    for (int i = 1; i <= 60 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done_o) lat = i;
    end
    check("basic_latency", lat, 33);
    check("basic_rd_data", rd_data_o, DEVICE_ID);
    @(posedge clk); #1;
    check("basic_busy_clear", {busy_o, done_o}, 0);
    check("basic_cs_low_cycles", cs_low, 33);
    check("basic_wr_low_cycles", wr_low, 3);
    check("basic_index_on_bus", last_idx, REG_DEVICE_CODE);

    // Start while panel not ready is ignored
    lcd_ready_i = 1'b0;
    cs_low = 0;
    busy_cnt = 0;
    base_done = done_cnt;
    base_abort = abort_cnt;
    reg_addr_i = 16'h0001;
    start_i = 1'b1;
    repeat (5) @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("notready_bus_idle", cs_low, 0);
    check("notready_busy", busy_cnt, 0);
    check("notready_done_abort", (done_cnt - base_done) + (abort_cnt - base_abort), 0);
    lcd_ready_i = 1'b1;
    run_txn(16'h00A5, 0, 0, lat, ab);
    check("ready_read_latency", lat, 33);
    check("ready_read_data", rd_data_o, 16'h1234);
    check("ready_read_index", last_idx, 16'h00A5);

    // Second start while busy is dropped
    base_done = done_cnt;
    run_txn(REG_DEVICE_CODE, 10, 0, lat, ab);
    check("busy_start_latency", lat, 33);
    check("busy_start_rd_data", rd_data_o, DEVICE_ID);
    repeat (40) @(posedge clk); #1;
    check("busy_start_one_done", done_cnt - base_done, 1);
    check("busy_start_idle", busy_o, 0);

    // Ready drop during RD_LOW
    base_done = done_cnt;
    base_abort = abort_cnt;
    run_txn(16'h00A5, 0, 16, lat, ab);
    check("drop_abort_edge", ab, 16);
    check("drop_no_done_seen", lat, -1);
    check("drop_bus_idle", {lcd_cs_n_o, lcd_wr_n_o, lcd_rd_n_o, lcd_data_oe_o, busy_o}, 5'b11100);
    check("drop_rd_data_kept", rd_data_o, DEVICE_ID);
    @(posedge clk); #1;
    check("drop_abort_pulse", abort_o, 0);
    check("drop_done_count", done_cnt - base_done, 0);
    check("drop_abort_count", abort_cnt - base_abort, 1);
    lcd_ready_i = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of the index write
    reg_addr_i = 16'h00A5;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk); #3;
    check("pre_reset_wr_low", lcd_wr_n_o, 0);
    rst_n = 1'b0;
    #1;
    check("areset_bus", {lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_rd_n_o, lcd_data_oe_o}, 5'b11110);
    check("areset_data_o", lcd_data_o, 0);
    check("areset_status", {busy_o, done_o, abort_o}, 0);
    check("areset_rd_data", rd_data_o, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(16'h00A5, 0, 0, lat, ab);
    check("post_reset_latency", lat, 33);
    check("post_reset_rd_data", rd_data_o, 16'h1234);

    // Back-to-back reads with start held high
    base_done = done_cnt;
    sb_q.push_back(DEVICE_ID);
    sb_q.push_back(DEVICE_ID);
    reg_addr_i = REG_DEVICE_CODE;
    start_i = 1'b1;
    d1 = -1;
    d2 = -1;
    idle_gap = 0;
    for (int i = 1; i <= 120 && d2 < 0; i++) begin
      @(posedge clk); #1;
      if (done_o) begin
        if (d1 < 0) d1 = i;
        else d2 = i;
      end else if (d1 >= 0 && !busy_o) begin
        idle_gap++;
      end
    end
    start_i = 1'b0;
    check("b2b_spacing", d2 - d1, 35);
    check("b2b_idle_cycles", idle_gap, 1);
    repeat (40) @(posedge clk); #1;
    check("b2b_done_count", done_cnt - base_done, 2);
    check("b2b_stopped", busy_o, 0);

    check("protocol_violations", prot_err, 0);
    check("sb_empty", sb_q.size(), 0);
    check("sb_underflow", sb_underflow, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
